// File: rtl/viterbi_pkg.sv
// Shared constants and types for the Viterbi survivor output stage.
//   NUM_COLS / NUM_ROWS : geometry of the survivor shift memory (8 columns x 4 rows)
//   SR_LEN              : survivor register length in bits
//   COL_* / ROW_*       : bit positions of the column and row fields inside best_state
//   state_t             : FSM encoding of survivor_bit_out
package viterbi_pkg;

  localparam int NUM_COLS = 8;
  localparam int NUM_ROWS = 4;
  localparam int SR_LEN   = 8;

  localparam int COL_W = $clog2(NUM_COLS);
  localparam int ROW_W = $clog2(NUM_ROWS);

  localparam int COL_LSB = 2;
  localparam int COL_MSB = 4;
  localparam int ROW_LSB = 0;
  localparam int ROW_MSB = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_COL = 2'd1,
    FLUSH    = 2'd2
  } state_t;

endpackage

// File: rtl/bit_fifo.sv
// Small FIFO of 2-bit entries {last, bit}.
//   clk, rst (async active-low)
//   push, push_data : write request; ignored when full unless a pop happens in the same cycle
//   pop             : read request; ignored when empty
//   head            : entry at the head, read combinationally; 0 when empty
//   full, empty     : occupancy flags
module bit_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [1:0] push_data,
  input  logic       pop,
  output logic [1:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? 2'b00 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/survivor_bit_out.sv
// Output stage of the survivor shift memory. Tracks which column the memory is
// presenting, captures the survivor register of the requested best state and
// emits either its oldest bit or, at frame end, all tail bits oldest-first.
//   clk, rst (async active-low)
//   data_in     : current column word, byte r = survivor register of row r, bit 7 oldest
//   best_valid  : request strobe; best_state = {column[2:0], row[1:0]}; frame_end = flush
//   out_valid / out_bit / out_last / out_ready : output FIFO handshake
//   busy        : a request is in progress
//   overflow    : sticky, a normal-mode bit was dropped on a full FIFO
//   req_drop    : sticky, a request arrived while busy
module survivor_bit_out #(
  parameter int FIFO_DEPTH = 8,
  parameter int SR_LEN     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        best_valid,
  input  logic [4:0]  best_state,
  input  logic        frame_end,
  output logic        out_valid,
  output logic        out_bit,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic        overflow,
  output logic        req_drop
);

  import viterbi_pkg::*;

  localparam int IDX_W = $clog2(SR_LEN);

  state_t             state_reg, state_next;
  logic [COL_W-1:0]   col_cnt_reg;
  logic [COL_W-1:0]   lat_col_reg, lat_col_next;
  logic [ROW_W-1:0]   lat_row_reg, lat_row_next;
  logic               lat_flush_reg, lat_flush_next;
  logic [SR_LEN-1:0]  hold_reg, hold_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               overflow_reg, req_drop_reg;

  logic [SR_LEN-1:0]  row_bytes [NUM_ROWS];
  logic [SR_LEN-1:0]  sel_byte;
  logic               cap_en, cap_flush;
  logic [ROW_W-1:0]   cap_row;
  logic               fifo_push, fifo_full, fifo_empty, fifo_accept;
  logic [1:0]         fifo_push_data, fifo_head;
  logic               ovf_set, drop_set;

  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_rows
    assign row_bytes[gi] = data_in[gi*SR_LEN +: SR_LEN];
  end

  assign sel_byte    = row_bytes[cap_row];
  assign fifo_accept = ~fifo_full | out_ready;

  always_comb begin
    state_next     = state_reg;
    lat_col_next   = lat_col_reg;
    lat_row_next   = lat_row_reg;
    lat_flush_next = lat_flush_reg;
    hold_next      = hold_reg;
    idx_next       = idx_reg;
    cap_en         = 1'b0;
    cap_row        = lat_row_reg;
    cap_flush      = lat_flush_reg;
    fifo_push      = 1'b0;
    fifo_push_data = 2'b00;
    ovf_set        = 1'b0;
    drop_set       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (best_valid) begin
          lat_col_next   = best_state[COL_MSB:COL_LSB];
          lat_row_next   = best_state[ROW_MSB:ROW_LSB];
          lat_flush_next = frame_end;
          // Column already on the bus: capture with zero latency.
          if (best_state[COL_MSB:COL_LSB] == col_cnt_reg) begin
            cap_en    = 1'b1;
            cap_row   = best_state[ROW_MSB:ROW_LSB];
            cap_flush = frame_end;
          end else begin
            state_next = WAIT_COL;
          end
        end
      end
      WAIT_COL: begin
        drop_set = best_valid;
        if (col_cnt_reg == lat_col_reg) begin
          cap_en     = 1'b1;
          state_next = IDLE;
        end
      end
      FLUSH: begin
        drop_set = best_valid;
        // Stall with idx held while the FIFO cannot take the bit.
        if (fifo_accept) begin
          fifo_push      = 1'b1;
          fifo_push_data = {(idx_reg == '0), hold_reg[idx_reg]};
          if (idx_reg == '0) state_next = IDLE;
          else               idx_next   = idx_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (cap_en) begin
      if (cap_flush) begin
        hold_next  = sel_byte;
        idx_next   = IDX_W'(SR_LEN - 1);
        state_next = FLUSH;
      end else begin
        fifo_push      = 1'b1;
        fifo_push_data = {1'b0, sel_byte[SR_LEN-1]};
        ovf_set        = ~fifo_accept;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      col_cnt_reg   <= '0;
      lat_col_reg   <= '0;
      lat_row_reg   <= '0;
      lat_flush_reg <= 1'b0;
      hold_reg      <= '0;
      idx_reg       <= '0;
      overflow_reg  <= 1'b0;
      req_drop_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      col_cnt_reg   <= col_cnt_reg + 1'b1;
      lat_col_reg   <= lat_col_next;
      lat_row_reg   <= lat_row_next;
      lat_flush_reg <= lat_flush_next;
      hold_reg      <= hold_next;
      idx_reg       <= idx_next;
      overflow_reg  <= overflow_reg | ovf_set;
      req_drop_reg  <= req_drop_reg | drop_set;
    end
  end

  bit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (out_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_bit   = fifo_head[0];
  assign out_last  = fifo_head[1];
  assign busy      = (state_reg != IDLE);
  assign overflow  = overflow_reg;
  assign req_drop  = req_drop_reg;

endmodule

// File: tb/tb_survivor_bit_out.sv
module tb_survivor_bit_out;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in;
  logic        best_valid = 1'b0;
  logic [4:0]  best_state = '0;
  logic        frame_end = 1'b0;
  logic        out_valid, out_bit, out_last;
  logic        out_ready = 1'b0;
  logic        busy, overflow, req_drop;

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_q [$];
  logic [31:0] cols [8];
  logic [2:0]  tb_col;

  survivor_bit_out #(.FIFO_DEPTH(8), .SR_LEN(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .best_valid (best_valid),
    .best_state (best_state),
    .frame_end  (frame_end),
    .out_valid  (out_valid),
    .out_bit    (out_bit),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .overflow   (overflow),
    .req_drop   (req_drop)
  );

  always #5 clk = ~clk;

  // Model of the shift memory's column selector, same reset as the DUT.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_col <= 3'd0;
    else      tb_col <= tb_col + 3'd1;
  end
  assign data_in = cols[tb_col];

  // Monitor: every accepted output is compared with the scoreboard head.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      logic [1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got last=%0b bit=%0b, required no output", out_last, out_bit);
      end else begin
        e = exp_q.pop_front();
        if ({out_last, out_bit} !== e) begin
          errors++;
          $display("FAIL out_data: got last=%0b bit=%0b, required last=%0b bit=%0b",
                   out_last, out_bit, e[1], e[0]);
        end else begin
          $display("pop: last=%0b bit=%0b ok", out_last, out_bit);
        end
      end
    end
  end

  task automatic check(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b", name, got, req);
    end else begin
      $display("check %s: %0b ok", name, got);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic exp_push(input logic last, input logic b);
    exp_q.push_back({last, b});
  endtask

  task automatic request(input logic [2:0] col, input logic [1:0] row, input logic fe);
    best_valid = 1'b1;
    best_state = {col, row};
    frame_end  = fe;
    tick();
    best_valid = 1'b0;
    frame_end  = 1'b0;
  endtask

  task automatic wait_col(input logic [2:0] k);
    for (int i = 0; i < 8 && tb_col != k; i++) tick();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid || busy) && n < 64) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL %s_drain: %0d entries still expected after 64 cycles, required 0", name, exp_q.size());
    end else begin
      $display("drain %s: done in %0d cycles", name, n);
    end
  endtask

  task automatic fill(input int n);
    logic [2:0] c;
    logic [1:0] r;
    for (int i = 0; i < n; i++) begin
      c = tb_col;
      r = 2'(i % 4);
      exp_push(1'b0, cols[c][8*r+7]);
      request(c, r, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] a5;
    logic [2:0] c;
    a5 = 8'hA5;
    cols[0] = 32'h0000_7F80;
    cols[1] = 32'h8000_0000;
    cols[2] = 32'h0080_0080;
    cols[3] = 32'h0080_0000;
    cols[4] = 32'h8000_8000;
    cols[5] = 32'h0000_0080;
    cols[6] = 32'h8080_8080;
    cols[7] = 32'h0000_A500;

    #12 rst = 1'b1;
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_bit",   out_bit,   1'b0);
    check("rst_busy",      busy,      1'b0);
    check("rst_overflow",  overflow,  1'b0);
    check("rst_req_drop",  req_drop,  1'b0);

    // 1: column 3 row 2 requested at column 1, two cycles of wait.
    out_ready = 1'b1;
    wait_col(3'd1);
    exp_push(1'b0, 1'b1);
    request(3'd3, 2'd2, 1'b0);
    check("t1_busy_c1", busy, 1'b1);
    tick();
    check("t1_busy_c2", busy, 1'b1);
    tick();
    check("t1_busy_done", busy, 1'b0);
    check("t1_out_valid", out_valid, 1'b1);
    drain("t1");

    // 2: zero-latency capture, busy never asserts.
    wait_col(3'd0);
    exp_push(1'b0, 1'b1);
    request(3'd0, 2'd0, 1'b0);
    check("t2_busy", busy, 1'b0);
    wait_col(3'd0);
    exp_push(1'b0, 1'b0);
    request(3'd0, 2'd1, 1'b0);
    check("t2b_busy", busy, 1'b0);
    drain("t2");

    // 3: flush of column 7 row 1 = A5.
    wait_col(3'd4);
    for (int i = 7; i >= 0; i--) exp_push(i == 0, a5[i]);
    request(3'd7, 2'd1, 1'b1);
    drain("t3");

    // 4: flush into a FIFO already holding 6 entries, consumer stalled.
    out_ready = 1'b0;
    fill(6);
    wait_col(3'd7);
    for (int i = 7; i >= 0; i--) exp_push(i == 0, a5[i]);
    request(3'd7, 2'd1, 1'b1);
    repeat (5) tick();
    check("t4_stalled_busy", busy, 1'b1);
    check("t4_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    drain("t4");
    check("t4_overflow", overflow, 1'b0);

    // 5: overflow on a full FIFO, then a simultaneous push/pop on full.
    out_ready = 1'b0;
    fill(8);
    c = tb_col;
    request(c, 2'd0, 1'b0);
    check("t5_overflow_set", overflow, 1'b1);
    repeat (3) tick();
    check("t5_overflow_sticky", overflow, 1'b1);
    c = tb_col;
    exp_push(1'b0, cols[c][7]);
    out_ready = 1'b1;
    request(c, 2'd0, 1'b0);
    drain("t5");
    check("t5_overflow_kept", overflow, 1'b1);

    // 6: request during WAIT_COL is dropped.
    c = tb_col + 3'd4;
    exp_push(1'b0, cols[c][8*3+7]);
    request(c, 2'd3, 1'b0);
    request(tb_col, 2'd0, 1'b0);
    check("t6_req_drop", req_drop, 1'b1);
    drain("t6");

    // 6b: reset in the middle of a flush.
    out_ready = 1'b0;
    wait_col(3'd7);
    request(3'd7, 2'd1, 1'b1);
    tick();
    tick();
    check("t6_busy_flush", busy, 1'b1);
    #1 rst = 1'b0;
    #1;
    exp_q.delete();
    check("t6_rst_out_valid", out_valid, 1'b0);
    check("t6_rst_out_bit",   out_bit,   1'b0);
    check("t6_rst_out_last",  out_last,  1'b0);
    check("t6_rst_busy",      busy,      1'b0);
    check("t6_rst_overflow",  overflow,  1'b0);
    check("t6_rst_req_drop",  req_drop,  1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    check("t6_post_rst_empty", out_valid, 1'b0);

    // Column tracking restarts with reset.
    out_ready = 1'b1;
    wait_col(3'd1);
    exp_push(1'b0, 1'b1);
    request(3'd3, 2'd2, 1'b0);
    drain("t6_post");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d entries left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
